// File: rtl/masked_and_scheduler.sv
// masked_and_scheduler
// Shares one D-share masked AND gadget between N requesters. The block does
// round-robin arbitration, operand muxing, fresh randomness per operation from
// a 32-bit Galois LFSR, and LAT-cycle sequencing of the gadget.
//
// Handshake: req[r] is a level request that the requester holds until it sees
// ack[r]. ack[r] is a one-cycle pulse. rsp_data/rsp_id are valid in the ack
// cycle and hold their values afterwards. Changes to req while busy are ignored
// until the block returns to IDLE.
//
// Optional feature macro: MASKED_AND_RESEED_EN adds seed_valid/seed ports
// that reload the LFSR. A zero seed reloads SEED, because an all-zero LFSR
// would lock up.
module masked_and_scheduler #(
  parameter int          D    = 2,
  parameter int          N    = 2,
  parameter int          LAT  = 1,
  parameter logic [31:0] SEED = 32'hACE1_2025,
  localparam int         IW   = (N > 1) ? $clog2(N) : 1,
  localparam int         R    = D * (D - 1) / 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*D-1:0] req_a,
  input  logic [N*D-1:0] req_b,
  output logic [N-1:0]   ack,
  output logic [D-1:0]   rsp_data,
  output logic [IW-1:0]  rsp_id,
  output logic           busy,
  output logic           err,
`ifdef MASKED_AND_RESEED_EN
  input  logic           seed_valid,
  input  logic [31:0]    seed,
`endif
  output logic [D-1:0]   and_ina,
  output logic [D-1:0]   and_inb,
  output logic [R-1:0]   and_rin,
  output logic           and_enable,
  input  logic           and_done,
  input  logic [D-1:0]   and_out
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_ISSUE   = 2'd1;
  localparam logic [1:0]  S_WAIT    = 2'd2;
  localparam logic [1:0]  S_CAPTURE = 2'd3;

  // Taps of x^32+x^22+x^2+x+1 for a right-shifting Galois LFSR.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  // WAIT lasts LAT-1 cycles; the counter runs from LAT-2 down to 0.
  localparam logic [1:0]  WAIT_LOAD = 2'((LAT > 1) ? LAT - 2 : 0);
  localparam logic [N-1:0] ACK_ONE  = 1;

  logic [1:0]    state;
  logic [1:0]    wait_cnt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] id_q;
  logic [D-1:0]  a_q;
  logic [D-1:0]  b_q;
  logic [R-1:0]  rin_q;
  logic [31:0]   lfsr;
  logic [31:0]   lfsr_next;
  logic          grant_vld;
  logic [IW-1:0] grant_idx;

  assign lfsr_next  = {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & LFSR_TAPS);

  // Gadget inputs come straight from the latch registers, so they hold their
  // values from ISSUE through CAPTURE and keep the last operation in IDLE.
  assign and_ina    = a_q;
  assign and_inb    = b_q;
  assign and_rin    = rin_q;
  assign and_enable = (state != S_IDLE);
  assign busy       = (state != S_IDLE);

  // Round-robin pick: first set req bit at or above rr_ptr, wrapping around.
  // The loop runs downward so the smallest offset is the last one written.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % N]) begin
        grant_vld = 1'b1;
        grant_idx = IW'((int'(rr_ptr) + i) % N);
      end
    end
  end

  // LFSR steps every cycle. A reseed load takes priority over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
`ifdef MASKED_AND_RESEED_EN
    end else if (seed_valid) begin
      lfsr <= (seed == 32'd0) ? SEED : seed;
`endif
    end else begin
      lfsr <= lfsr_next;
    end
  end

  // Control FSM: grant and latch, then issue, wait, and capture the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      rr_ptr   <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rin_q    <= '0;
      ack      <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      err      <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            id_q  <= grant_idx;
            a_q   <= req_a[grant_idx*D +: D];
            b_q   <= req_b[grant_idx*D +: D];
            rin_q <= lfsr[R-1:0];
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= (LAT > 1) ? S_WAIT : S_CAPTURE;
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: begin
          rsp_data <= and_out;
          rsp_id   <= id_q;
          ack      <= ACK_ONE << id_q;
          // and_done is sticky in the gadget, so it is only checked here and
          // never used for timing.
          if (!and_done) begin
            err <= 1'b1;
          end
          rr_ptr <= (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_masked_and_scheduler.sv
// Testbench for masked_and_scheduler (D=3, N=3, LAT=2) with a behavioural
// one-register gadget and a reference LFSR. Define MASKED_AND_RESEED_EN to
// also exercise the reseed ports.
module tb_masked_and_scheduler;

  localparam int          D    = 3;
  localparam int          N    = 3;
  localparam int          LAT  = 2;
  localparam int          R    = D * (D - 1) / 2;
  localparam logic [31:0] SEED = 32'hACE1_2025;

  typedef struct {
    logic [N-1:0]   rq;
    logic [N*D-1:0] a;
    logic [N*D-1:0] b;
    int             exp_id;
  } vec_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*D-1:0] req_a;
  logic [N*D-1:0] req_b;
  logic [N-1:0]   ack;
  logic [D-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;
  logic           err;
  logic [D-1:0]   and_ina;
  logic [D-1:0]   and_inb;
  logic [R-1:0]   and_rin;
  logic           and_enable;
  logic           and_done;
  logic [D-1:0]   and_out;
`ifdef MASKED_AND_RESEED_EN
  logic           seed_valid;
  logic [31:0]    seed;
`endif

  int   n_checks;
  int   n_errors;
  int   cyc;
  logic kill_done;
  logic exp_err;
  logic [D-1:0] g_out;
  logic         g_done;
  logic [31:0]  m_lfsr;
  vec_t         vecs[8];

  masked_and_scheduler #(.D(D), .N(N), .LAT(LAT), .SEED(SEED)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .ack        (ack),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .err        (err),
`ifdef MASKED_AND_RESEED_EN
    .seed_valid (seed_valid),
    .seed       (seed),
`endif
    .and_ina    (and_ina),
    .and_inb    (and_inb),
    .and_rin    (and_rin),
    .and_enable (and_enable),
    .and_done   (and_done),
    .and_out    (and_out)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 1;

  // ---------------- gadget model and reference LFSR ----------------
  function automatic logic [D-1:0] gfunc(input logic [D-1:0] a, b, input logic [R-1:0] rin);
    logic p, r;
    p = (^a) & (^b);
    r = ^rin;
    return {1'b0, r, p ^ r};
  endfunction

  function automatic logic [31:0] lstep(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_out  <= '0;
      g_done <= 1'b0;
    end else if (and_enable) begin
      g_out  <= gfunc(and_ina, and_inb, and_rin);
      g_done <= 1'b1;
    end
  end
  assign and_out  = g_out;
  assign and_done = g_done & ~kill_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
`ifdef MASKED_AND_RESEED_EN
    else if (seed_valid) m_lfsr <= (seed == 32'd0) ? SEED : seed;
`endif
    else m_lfsr <= lstep(m_lfsr);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Waits (bounded) for a nonzero ack, sampling on negedges.
  task automatic wait_ack(input string nm, output bit got);
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if (ack != '0) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no ack within 16 cycles", nm);
    end
  endtask

  // One full operation from an idle scheduler, with all result checks.
  task automatic do_op(input logic [N-1:0] rq, input logic [N*D-1:0] aa, bb,
                       input int eid, input string nm);
    logic [D-1:0] ea, eb;
    logic [R-1:0] er;
    int t0;
    bit got;
    @(negedge clk);
    req   = rq;
    req_a = aa;
    req_b = bb;
    t0    = cyc;
    er    = m_lfsr[R-1:0];
    ea    = aa[eid*D +: D];
    eb    = bb[eid*D +: D];
    @(negedge clk);
    chk({nm, ".busy"}, 32'(busy), 32'd1);
    chk({nm, ".enable"}, 32'(and_enable), 32'd1);
    chk({nm, ".ina"}, 32'(and_ina), 32'(ea));
    chk({nm, ".inb"}, 32'(and_inb), 32'(eb));
    chk({nm, ".rin"}, 32'(and_rin), 32'(er));
    wait_ack(nm, got);
    if (got) begin
      chk({nm, ".latency"}, 32'(cyc - t0), 32'(2 + LAT));
      chk({nm, ".ack"}, 32'(ack), 32'(1 << eid));
      chk({nm, ".id"}, 32'(rsp_id), 32'(eid));
      chk({nm, ".data"}, 32'(rsp_data), 32'(gfunc(ea, eb, er)));
      chk({nm, ".xor"}, 32'(^rsp_data), 32'((^ea) & (^eb)));
      chk({nm, ".err"}, 32'(err), 32'(exp_err));
      chk({nm, ".idle"}, 32'(busy), 32'd0);
    end
    req = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [N*D-1:0] aa, bb;
    logic [R-1:0]   er;
    logic [N-1:0]   exp_ack;
    logic [D-1:0]   ea, eb;
    int  t_last, eid, n_spurious;
    bit  got;

    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    kill_done = 1'b0;
    exp_err   = 1'b0;
    req       = '0;
    req_a     = '0;
    req_b     = '0;
    rst_n     = 1'b0;
`ifdef MASKED_AND_RESEED_EN
    seed_valid = 1'b0;
    seed       = '0;
`endif

    // Arbitration table, rr pointer 0 after reset; ids worked out by hand.
    vecs[0] = '{3'b001, 9'o765, 9'o123, 0};
    vecs[1] = '{3'b101, 9'o654, 9'o707, 2};
    vecs[2] = '{3'b111, 9'o011, 9'o033, 0};
    vecs[3] = '{3'b111, 9'o572, 9'o216, 1};
    vecs[4] = '{3'b011, 9'o347, 9'o765, 0};
    vecs[5] = '{3'b100, 9'o400, 9'o300, 2};
    vecs[6] = '{3'b010, 9'o070, 9'o060, 1};
    vecs[7] = '{3'b111, 9'o135, 9'o642, 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.enable", 32'(and_enable), 32'd0);
    chk("rst.ina", 32'(and_ina), 32'd0);
    chk("rst.inb", 32'(and_inb), 32'd0);
    chk("rst.rin", 32'(and_rin), 32'd0);
    chk("rst.data", 32'(rsp_data), 32'd0);
    chk("rst.id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;

    // Table-driven arbitration vectors
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].rq, vecs[i].a, vecs[i].b, vecs[i].exp_id, $sformatf("vec%0d", i));
    end

    // All 64 operand share pairs, spread across single requesters
    for (int i = 0; i < 64; i++) begin
      eid = i % N;
      aa = '0;
      bb = '0;
      aa[eid*D +: D] = 3'(i >> 3);
      bb[eid*D +: D] = 3'(i);
      do_op(3'(1 << eid), aa, bb, eid, $sformatf("exh%0d", i));
    end

    // Park the pointer at 0, then hold req=011: acks alternate, one per 2+LAT
    do_op(3'b100, 9'o500, 9'o300, 2, "rr_park");
    @(negedge clk);
    aa     = 9'o056;
    bb     = 9'o071;
    req    = 3'b011;
    req_a  = aa;
    req_b  = bb;
    t_last = cyc;
    er     = m_lfsr[R-1:0];
    for (int n = 0; n < 4; n++) begin
      eid     = n % 2;
      exp_ack = 3'(1 << eid);
      ea      = aa[eid*D +: D];
      eb      = bb[eid*D +: D];
      wait_ack($sformatf("rr%0d", n), got);
      if (got) begin
        chk($sformatf("rr%0d.spacing", n), 32'(cyc - t_last), 32'(2 + LAT));
        chk($sformatf("rr%0d.ack", n), 32'(ack), 32'(exp_ack));
        chk($sformatf("rr%0d.data", n), 32'(rsp_data), 32'(gfunc(ea, eb, er)));
        chk($sformatf("rr%0d.rin", n), 32'(and_rin), 32'(er));
      end
      t_last = cyc;
      er     = m_lfsr[R-1:0];
      if (n == 3) req = '0;
    end

    // Reset in the middle of WAIT: everything clears, no ack afterwards
    @(negedge clk);
    req   = 3'b001;
    req_a = 9'o007;
    req_b = 9'o007;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("midrst.ack", 32'(ack), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.enable", 32'(and_enable), 32'd0);
    chk("midrst.ina", 32'(and_ina), 32'd0);
    chk("midrst.rin", 32'(and_rin), 32'd0);
    chk("midrst.data", 32'(rsp_data), 32'd0);
    n_spurious = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack != '0) n_spurious++;
    end
    chk("midrst.no_ack", 32'(n_spurious), 32'd0);
    // Release with a request pending: the latched rin is the low SEED bits
    rst_n = 1'b1;
    req   = 3'b010;
    req_a = 9'o070;
    req_b = 9'o050;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.seed_rin", 32'(and_rin), 32'(SEED[R-1:0]));
    wait_ack("midrst.op", got);
    if (got) chk("midrst.op_id", 32'(rsp_id), 32'd1);
    req = '0;

    // Gadget reports not-done: err sets and stays set
    kill_done = 1'b1;
    exp_err   = 1'b1;
    do_op(3'b001, 9'o003, 9'o001, 0, "err1");
    kill_done = 1'b0;
    do_op(3'b010, 9'o020, 9'o030, 1, "err2");

`ifdef MASKED_AND_RESEED_EN
    // Reseed with 1, then with 0 (falls back to SEED)
    @(negedge clk);
    seed_valid = 1'b1;
    seed       = 32'h1;
    @(negedge clk);
    seed_valid = 1'b0;
    chk("reseed.one_rin_pre", 32'(m_lfsr), 32'h1);
    do_op(3'b100, 9'o700, 9'o500, 2, "reseed1");
    @(negedge clk);
    seed_valid = 1'b1;
    seed       = 32'h0;
    @(negedge clk);
    seed_valid = 1'b0;
    do_op(3'b001, 9'o006, 9'o005, 0, "reseed0");
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
